writeback_commit_unit_l4: RTL and testbench
===========================================

WRITEBACK_COMMIT_UNIT_L4 -- requirements
Module: writeback_commit_unit_l4

Interface
REQ-001 SHALL have parameter p_num_pipes, default 2: number of execute pipes arbitrated.
REQ-002 SHALL have parameter p_seq_num_bits, default 5: sequence number width; ROB depth is 2**p_seq_num_bits.
REQ-003 SHALL have parameter p_phys_addr_bits, default 6: physical register specifier width.
REQ-004 SHALL have parameter p_commit_width, default 2: maximum commits per cycle, 1..4.
REQ-005 SHALL have port clk  in  1: sole clock, rising edge.
REQ-006 SHALL have port rst  in  1: reset, asynchronous and active-low.
REQ-007 SHALL have ports ex_val, ex_wen  in  N (N = p_num_pipes): per-pipe valid and write-enable.
REQ-008 SHALL have ports ex_pc, ex_wdata  in  N*32; ex_seq_num  in  N*S; ex_waddr  in  N*5; ex_preg, ex_ppreg  in  N*P: per-pipe payload, pipe i at slice i.
REQ-009 SHALL have port ex_rdy  out  N: per-pipe accept.
REQ-010 SHALL have ports complete_val, complete_wen  out  1; complete_seq_num  out  S; complete_waddr  out  5; complete_wdata  out  32; complete_preg  out  P.
REQ-011 SHALL have port commit_rdy  in  1: consumer accepts all offered commit slots.
REQ-012 SHALL have ports commit_val, commit_wen  out  C; commit_pc, commit_wdata  out  C*32; commit_seq_num  out  C*S; commit_waddr  out  C*5; commit_ppreg  out  C*P (C = p_commit_width).

Function
REQ-013 SHALL keep head register (S bits) = oldest uncommitted sequence number.
REQ-014 SHALL grant at most one pipe per cycle: valid pipe with smallest age (seq_num - head) mod 2**S; ex_rdy[i] = grant[i]; ex_rdy all 0 when no pipe valid.
REQ-015 SHALL drive complete_* combinationally from granted pipe in grant cycle; complete_val = 1 iff a grant occurs.
REQ-016 SHALL force complete_wen and commit_wen to 0 when corresponding waddr = 0.
REQ-017 SHALL register granted payload (capture stage) one cycle, then write it into ROB entry seq_num, setting its valid bit at end of that cycle.
REQ-018 SHALL give grant-to-earliest-commit_val latency of exactly 2 cycles; no bypass.
REQ-019 SHALL assert commit_val[k] iff ROB entries head..head+k (mod 2**S) are all valid; slots are a contiguous prefix from slot 0.
REQ-020 SHALL drive commit_val independent of commit_rdy; commit_* payload of slot k from entry head+k.
REQ-021 SHALL, when commit_rdy = 1, clear valid bits of all offered slots and advance head by popcount(commit_val) mod 2**S; when commit_rdy = 0, hold head, entries and outputs.
REQ-022 SHALL wrap head from 2**S-1 to 0 and evaluate commit prefix across the wrap.
REQ-023 SHALL allow simultaneous ROB write and commit in the same cycle on distinct entries.
REQ-024 SHALL treat write to an already-valid entry as illegal; simulation-only assertion fires, excluded under SYNTHESIS.

Reset
REQ-025 SHALL, on rst low, asynchronously clear all ROB valid bits, capture-stage valid, head = 0.
REQ-026 SHALL hold ex_rdy, complete_val, commit_val all 0 while rst low; payload outputs are don't-care.
REQ-027 SHALL discard any in-flight capture-stage entry on reset mid-operation; first cycle after release behaves as empty.

Configuration
REQ-028 SHALL, with WRITEBACK_COMMIT_UNIT_L4_PERF_EN defined, add outputs perf_commit_cnt (32) and perf_stall_cnt (32), both reset to 0, wrapping.
REQ-029 SHALL increment perf_commit_cnt by popcount(commit_val) each cycle commit_rdy = 1; increment perf_stall_cnt by 1 each cycle commit_val[0] = 1 and commit_rdy = 0.
REQ-030 SHALL, without the macro, omit both ports and counter logic; all other behaviour identical.

Verification
REQ-031 SHALL cover: pipe0 seq 1, pipe1 seq 0, head 0, same cycle -> pipe1 granted (ex_rdy=2'b10), complete_seq_num 0; pipe0 granted next cycle.
REQ-032 SHALL cover: seq 0 granted cycle 0, commit_rdy=1 -> commit_val=2'b01 in cycle 2 only, head=1 cycle 3.
REQ-033 SHALL cover: seqs 2,1,0 granted cycles 0,1,2 -> no commit until cycle 4, then commit_val=2'b11 (seqs 0,1) cycle 4, seq 2 cycle 5.
REQ-034 SHALL cover: head=31 (S=5), entries 31 and 0 valid -> commit_val=2'b11, seq 31 then 0, head becomes 1.
REQ-035 SHALL cover: waddr 0, wen 1 -> complete_wen 0, commit_wen 0; commit_rdy=0 three cycles with entry valid -> outputs stable, perf_stall_cnt = 3 when macro defined.
REQ-036 SHALL cover: rst low while two entries valid and one in capture stage -> after release commit_val 0, head 0, no stale commit.

Source files
------------

// File: rtl/writeback_commit_unit_l4.sv
// rtl/writeback_commit_unit_l4.sv - age-ordered writeback arbiter, capture stage and in-order commit ROB
//
// Purpose: grants the oldest valid execute pipe each cycle, registers the
// granted result for one cycle, writes it into a reorder buffer indexed by
// sequence number, and retires a contiguous prefix of up to p_commit_width
// entries per cycle from the head.
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-low reset
//   ex_*                - per-pipe result payload, pipe i at slice i; ex_rdy = grant
//   complete_*          - combinational echo of the granted pipe
//   commit_rdy          - consumer takes every offered commit slot
//   commit_*            - commit slots, slot k = ROB entry head+k
//   perf_commit_cnt,
//   perf_stall_cnt      - only with WRITEBACK_COMMIT_UNIT_L4_PERF_EN defined
module writeback_commit_unit_l4 #(
    parameter int p_num_pipes      = 2,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6,
    parameter int p_commit_width   = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [p_num_pipes-1:0]                     ex_val,
    input  logic [p_num_pipes-1:0]                     ex_wen,
    input  logic [p_num_pipes*32-1:0]                  ex_pc,
    input  logic [p_num_pipes*32-1:0]                  ex_wdata,
    input  logic [p_num_pipes*p_seq_num_bits-1:0]      ex_seq_num,
    input  logic [p_num_pipes*5-1:0]                   ex_waddr,
    input  logic [p_num_pipes*p_phys_addr_bits-1:0]    ex_preg,
    input  logic [p_num_pipes*p_phys_addr_bits-1:0]    ex_ppreg,
    output logic [p_num_pipes-1:0]                     ex_rdy,
    output logic                                       complete_val,
    output logic                                       complete_wen,
    output logic [p_seq_num_bits-1:0]                  complete_seq_num,
    output logic [4:0]                                 complete_waddr,
    output logic [31:0]                                complete_wdata,
    output logic [p_phys_addr_bits-1:0]                complete_preg,
    input  logic                                       commit_rdy,
    output logic [p_commit_width-1:0]                  commit_val,
    output logic [p_commit_width-1:0]                  commit_wen,
    output logic [p_commit_width*32-1:0]               commit_pc,
    output logic [p_commit_width*32-1:0]               commit_wdata,
    output logic [p_commit_width*p_seq_num_bits-1:0]   commit_seq_num,
    output logic [p_commit_width*5-1:0]                commit_waddr,
    output logic [p_commit_width*p_phys_addr_bits-1:0] commit_ppreg
`ifdef WRITEBACK_COMMIT_UNIT_L4_PERF_EN
    ,
    output logic [31:0]                                perf_commit_cnt,
    output logic [31:0]                                perf_stall_cnt
`endif
);
    localparam int N = p_num_pipes;
    localparam int S = p_seq_num_bits;
    localparam int P = p_phys_addr_bits;
    localparam int C = p_commit_width;
    localparam int D = 1 << S;

    logic [S-1:0]  head;
    logic [D-1:0]  rob_valid;
    logic [D-1:0]  rob_valid_nxt;
    logic [31:0]   rob_pc    [D];
    logic [31:0]   rob_wdata [D];
    logic [4:0]    rob_waddr [D];
    logic [P-1:0]  rob_ppreg [D];
    logic [D-1:0]  rob_wen;

    logic          cap_val;
    logic          cap_wen;
    logic [S-1:0]  cap_seq;
    logic [31:0]   cap_pc;
    logic [31:0]   cap_wdata;
    logic [4:0]    cap_waddr;
    logic [P-1:0]  cap_ppreg;

    logic [N-1:0]  grant;
    int            gidx;
    logic          found;
    logic [S-1:0]  age;
    logic [S-1:0]  best_age;
    logic [31:0]   sel_pc;
    logic [P-1:0]  sel_ppreg;
    logic          sel_wen;
    logic [S-1:0]  cidx;
    logic          prefix_ok;
    logic [3:0]    pop_cnt;

    // Age is measured relative to head so the comparison stays correct across
    // sequence-number wrap. Equal ages resolve to the lower pipe index.
    always_comb begin
        grant            = '0;
        gidx             = 0;
        found            = 1'b0;
        age              = '0;
        best_age         = '0;
        complete_seq_num = '0;
        complete_waddr   = '0;
        complete_wdata   = '0;
        complete_preg    = '0;
        sel_pc           = '0;
        sel_ppreg        = '0;
        sel_wen          = 1'b0;
        for (int i = 0; i < N; i++) begin
            age = ex_seq_num[i*S +: S] - head;
            if (ex_val[i] && (!found || age < best_age)) begin
                found    = 1'b1;
                best_age = age;
                gidx     = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            grant[i] = found && rst && (gidx == i);
            if (gidx == i) begin
                complete_seq_num = ex_seq_num[i*S +: S];
                complete_waddr   = ex_waddr[i*5 +: 5];
                complete_wdata   = ex_wdata[i*32 +: 32];
                complete_preg    = ex_preg[i*P +: P];
                sel_pc           = ex_pc[i*32 +: 32];
                sel_ppreg        = ex_ppreg[i*P +: P];
                sel_wen          = ex_wen[i];
            end
        end
    end

    assign ex_rdy       = grant;
    assign complete_val = |grant;
    assign complete_wen = sel_wen && (complete_waddr != 5'd0);

    // Commit slots form a contiguous prefix: slot k needs entries head..head+k.
    always_comb begin
        commit_val     = '0;
        commit_wen     = '0;
        commit_pc      = '0;
        commit_wdata   = '0;
        commit_seq_num = '0;
        commit_waddr   = '0;
        commit_ppreg   = '0;
        cidx           = '0;
        prefix_ok      = 1'b1;
        for (int k = 0; k < C; k++) begin
            cidx                    = head + S'(k);
            prefix_ok               = prefix_ok && rob_valid[cidx];
            commit_val[k]           = prefix_ok;
            commit_wen[k]           = rob_wen[cidx] && (rob_waddr[cidx] != 5'd0);
            commit_pc[k*32 +: 32]   = rob_pc[cidx];
            commit_wdata[k*32 +: 32] = rob_wdata[cidx];
            commit_seq_num[k*S +: S] = cidx;
            commit_waddr[k*5 +: 5]  = rob_waddr[cidx];
            commit_ppreg[k*P +: P]  = rob_ppreg[cidx];
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int k = 0; k < C; k++) begin
            pop_cnt = pop_cnt + {3'b000, commit_val[k]};
        end
    end

    // Retiring and the capture-stage write touch distinct entries in legal use.
    always_comb begin
        rob_valid_nxt = rob_valid;
        if (commit_rdy) begin
            for (int k = 0; k < C; k++) begin
                if (commit_val[k]) begin
                    rob_valid_nxt[head + S'(k)] = 1'b0;
                end
            end
        end
        if (cap_val) begin
            rob_valid_nxt[cap_seq] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rob_valid <= '0;
            head      <= '0;
            cap_val   <= 1'b0;
            cap_wen   <= 1'b0;
            cap_seq   <= '0;
            cap_pc    <= '0;
            cap_wdata <= '0;
            cap_waddr <= '0;
            cap_ppreg <= '0;
        end else begin
            rob_valid <= rob_valid_nxt;
            if (commit_rdy) begin
                head <= head + S'(pop_cnt);
            end
            cap_val <= complete_val;
            if (complete_val) begin
                cap_wen   <= complete_wen;
                cap_seq   <= complete_seq_num;
                cap_pc    <= sel_pc;
                cap_wdata <= complete_wdata;
                cap_waddr <= complete_waddr;
                cap_ppreg <= sel_ppreg;
            end
        end
    end

    // Entry payload carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (cap_val) begin
            rob_pc[cap_seq]    <= cap_pc;
            rob_wdata[cap_seq] <= cap_wdata;
            rob_waddr[cap_seq] <= cap_waddr;
            rob_ppreg[cap_seq] <= cap_ppreg;
            rob_wen[cap_seq]   <= cap_wen;
        end
    end

`ifdef WRITEBACK_COMMIT_UNIT_L4_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_commit_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else begin
            if (commit_rdy) begin
                perf_commit_cnt <= perf_commit_cnt + 32'(pop_cnt);
            end
            if (commit_val[0] && !commit_rdy) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && cap_val) begin
            assert (!rob_valid[cap_seq]);
        end
    end
`endif

endmodule

// File: tb/tb_writeback_commit_unit_l4.sv
// tb/tb_writeback_commit_unit_l4.sv - directed table and sequence bench for writeback_commit_unit_l4
module tb_writeback_commit_unit_l4;
    logic        clk;
    logic        rst;
    logic [1:0]  ex_val;
    logic [1:0]  ex_wen;
    logic [63:0] ex_pc;
    logic [63:0] ex_wdata;
    logic [9:0]  ex_seq_num;
    logic [9:0]  ex_waddr;
    logic [11:0] ex_preg;
    logic [11:0] ex_ppreg;
    logic [1:0]  ex_rdy;
    logic        complete_val;
    logic        complete_wen;
    logic [4:0]  complete_seq_num;
    logic [4:0]  complete_waddr;
    logic [31:0] complete_wdata;
    logic [5:0]  complete_preg;
    logic        commit_rdy;
    logic [1:0]  commit_val;
    logic [1:0]  commit_wen;
    logic [63:0] commit_pc;
    logic [63:0] commit_wdata;
    logic [9:0]  commit_seq_num;
    logic [9:0]  commit_waddr;
    logic [11:0] commit_ppreg;
`ifdef WRITEBACK_COMMIT_UNIT_L4_PERF_EN
    logic [31:0] perf_commit_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    writeback_commit_unit_l4 dut (
        .clk              (clk),
        .rst              (rst),
        .ex_val           (ex_val),
        .ex_wen           (ex_wen),
        .ex_pc            (ex_pc),
        .ex_wdata         (ex_wdata),
        .ex_seq_num       (ex_seq_num),
        .ex_waddr         (ex_waddr),
        .ex_preg          (ex_preg),
        .ex_ppreg         (ex_ppreg),
        .ex_rdy           (ex_rdy),
        .complete_val     (complete_val),
        .complete_wen     (complete_wen),
        .complete_seq_num (complete_seq_num),
        .complete_waddr   (complete_waddr),
        .complete_wdata   (complete_wdata),
        .complete_preg    (complete_preg),
        .commit_rdy       (commit_rdy),
        .commit_val       (commit_val),
        .commit_wen       (commit_wen),
        .commit_pc        (commit_pc),
        .commit_wdata     (commit_wdata),
        .commit_seq_num   (commit_seq_num),
        .commit_waddr     (commit_waddr),
        .commit_ppreg     (commit_ppreg)
`ifdef WRITEBACK_COMMIT_UNIT_L4_PERF_EN
        ,
        .perf_commit_cnt  (perf_commit_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  val;
        logic [4:0]  s0, s1;
        logic [4:0]  a0, a1;
        logic [1:0]  exp_rdy;
        logic        exp_cval;
        logic [4:0]  exp_seq;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic [5:0]  exp_preg;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [4:0] seq, input logic [4:0] wa, input logic [31:0] wd);
        ex_val[p]             = 1'b1;
        ex_wen[p]             = 1'b1;
        ex_seq_num[p*5 +: 5]  = seq;
        ex_waddr[p*5 +: 5]    = wa;
        ex_wdata[p*32 +: 32]  = wd;
        ex_pc[p*32 +: 32]     = 32'h1000 + {27'b0, seq};
        ex_ppreg[p*6 +: 6]    = {1'b0, seq};
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        ex_val     = '0;
        commit_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    vec_t vt[7];

    initial begin
        ex_val     = '0;
        ex_wen     = '0;
        ex_pc      = '0;
        ex_wdata   = '0;
        ex_seq_num = '0;
        ex_waddr   = '0;
        ex_preg    = {6'd22, 6'd11};
        ex_ppreg   = '0;
        commit_rdy = 1'b0;
        rst        = 1'b0;

        vt[0] = '{2'b00,  0,  0, 1, 1, 2'b00, 1'b0,  0, 1'b0, 32'h0,         6'd0};
        vt[1] = '{2'b01,  3,  7, 0, 4, 2'b01, 1'b1,  3, 1'b0, 32'hA0A0_0000, 6'd11};
        vt[2] = '{2'b10,  3,  7, 0, 4, 2'b10, 1'b1,  7, 1'b1, 32'hB1B1_0001, 6'd22};
        vt[3] = '{2'b11,  1,  0, 2, 0, 2'b10, 1'b1,  0, 1'b0, 32'hB1B1_0001, 6'd22};
        vt[4] = '{2'b11,  4,  9, 6, 0, 2'b01, 1'b1,  4, 1'b1, 32'hA0A0_0000, 6'd11};
        vt[5] = '{2'b11, 31, 30, 5, 5, 2'b10, 1'b1, 30, 1'b1, 32'hB1B1_0001, 6'd22};
        vt[6] = '{2'b11, 16, 15, 9, 9, 2'b10, 1'b1, 15, 1'b1, 32'hB1B1_0001, 6'd22};

        // reset state
        #2;
        chk("rst_ex_rdy", ex_rdy, 2'b00);
        chk("rst_commit_val", commit_val, 2'b00);
        do_reset();
        @(negedge clk);
        chk("post_rst_commit_val", commit_val, 2'b00);
        chk("post_rst_head", commit_seq_num[4:0], 5'd0);
`ifdef WRITEBACK_COMMIT_UNIT_L4_PERF_EN
        chk("post_rst_perf_commit", perf_commit_cnt, 32'd0);
        chk("post_rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        step();

        // combinational grant table, head = 0; inputs dropped before the edge
        for (int i = 0; i < 7; i++) begin
            ex_wen     = 2'b11;
            ex_val     = vt[i].val;
            ex_seq_num = {vt[i].s1, vt[i].s0};
            ex_waddr   = {vt[i].a1, vt[i].a0};
            ex_wdata   = {32'hB1B1_0001, 32'hA0A0_0000};
            @(negedge clk);
            chk($sformatf("tbl%0d_rdy", i), ex_rdy, vt[i].exp_rdy);
            chk($sformatf("tbl%0d_cval", i), complete_val, vt[i].exp_cval);
            if (vt[i].exp_cval) begin
                chk($sformatf("tbl%0d_seq", i), complete_seq_num, vt[i].exp_seq);
                chk($sformatf("tbl%0d_wen", i), complete_wen, vt[i].exp_wen);
                chk($sformatf("tbl%0d_wdata", i), complete_wdata, vt[i].exp_wdata);
                chk($sformatf("tbl%0d_preg", i), complete_preg, vt[i].exp_preg);
            end
            ex_val = '0;
            step();
        end

        // pipe1 (seq 0) beats pipe0 (seq 1), pipe0 follows next cycle
        do_reset();
        commit_rdy = 1'b1;
        drive(0, 5'd1, 5'd3, 32'h0000_0011);
        drive(1, 5'd0, 5'd4, 32'h0000_0010);
        @(negedge clk);
        chk("ord_rdy0", ex_rdy, 2'b10);
        chk("ord_seq0", complete_seq_num, 5'd0);
        step();
        ex_val = 2'b01;
        @(negedge clk);
        chk("ord_rdy1", ex_rdy, 2'b01);
        chk("ord_seq1", complete_seq_num, 5'd1);
        step();
        ex_val = '0;
        @(negedge clk);
        chk("ord_cval_c2", commit_val, 2'b01);
        chk("ord_cwdata_c2", commit_wdata[31:0], 32'h0000_0010);
        step();
        @(negedge clk);
        chk("ord_cval_c3", commit_val, 2'b01);
        chk("ord_cseq_c3", commit_seq_num[4:0], 5'd1);
        step();

        // single entry: commit exactly 2 cycles after grant, head advances
        do_reset();
        commit_rdy = 1'b1;
        drive(0, 5'd0, 5'd3, 32'h1111_2222);
        @(negedge clk);
        chk("lat_grant", ex_rdy, 2'b01);
        step();
        ex_val = '0;
        @(negedge clk);
        chk("lat_c1_cval", commit_val, 2'b00);
        step();
        @(negedge clk);
        chk("lat_c2_cval", commit_val, 2'b01);
        chk("lat_c2_seq", commit_seq_num[4:0], 5'd0);
        chk("lat_c2_wdata", commit_wdata[31:0], 32'h1111_2222);
        chk("lat_c2_pc", commit_pc[31:0], 32'h0000_1000);
        chk("lat_c2_waddr", commit_waddr[4:0], 5'd3);
        chk("lat_c2_wen", commit_wen[0], 1'b1);
        step();
        @(negedge clk);
        chk("lat_c3_cval", commit_val, 2'b00);
        chk("lat_c3_head", commit_seq_num[4:0], 5'd1);
`ifdef WRITEBACK_COMMIT_UNIT_L4_PERF_EN
        chk("lat_perf_commit", perf_commit_cnt, 32'd1);
`endif

        // out of order completion 2,1,0
        do_reset();
        commit_rdy = 1'b1;
        drive(0, 5'd2, 5'd7, 32'h0000_0202);
        step();
        drive(0, 5'd1, 5'd7, 32'h0000_0101);
        step();
        drive(0, 5'd0, 5'd7, 32'h0000_0000);
        @(negedge clk);
        chk("ooo_c2_cval", commit_val, 2'b00);
        step();
        ex_val = '0;
        @(negedge clk);
        chk("ooo_c3_cval", commit_val, 2'b00);
        step();
        @(negedge clk);
        chk("ooo_c4_cval", commit_val, 2'b11);
        chk("ooo_c4_seq", commit_seq_num, {5'd1, 5'd0});
        chk("ooo_c4_wdata1", commit_wdata[63:32], 32'h0000_0101);
        step();
        @(negedge clk);
        chk("ooo_c5_cval", commit_val, 2'b01);
        chk("ooo_c5_seq", commit_seq_num[4:0], 5'd2);
        step();
        @(negedge clk);
        chk("ooo_c6_cval", commit_val, 2'b00);
        step();

        // walk head to 31, then commit 31 and 0 across the wrap
        do_reset();
        commit_rdy = 1'b1;
        for (int s = 0; s < 31; s++) begin
            drive(0, 5'(s), 5'd1, 32'(s));
            step();
        end
        ex_val = '0;
        repeat (3) step();
        @(negedge clk);
        chk("wrap_head31_cval", commit_val, 2'b00);
        chk("wrap_head31", commit_seq_num[4:0], 5'd31);
        step();
        commit_rdy = 1'b0;
        drive(0, 5'd31, 5'd2, 32'h0000_3131);
        step();
        drive(0, 5'd0, 5'd2, 32'h0000_0A0A);
        step();
        ex_val = '0;
        step();
        @(negedge clk);
        chk("wrap_cval", commit_val, 2'b11);
        chk("wrap_seq", commit_seq_num, {5'd0, 5'd31});
        chk("wrap_wdata", commit_wdata, {32'h0000_0A0A, 32'h0000_3131});
        step();
        commit_rdy = 1'b1;
        @(negedge clk);
        chk("wrap_cval_rdy", commit_val, 2'b11);
        step();
        @(negedge clk);
        chk("wrap_after_cval", commit_val, 2'b00);
        chk("wrap_after_head", commit_seq_num[4:0], 5'd1);

        // waddr 0 kills wen; commit_rdy low holds outputs for three cycles
        do_reset();
        drive(0, 5'd0, 5'd0, 32'hDEAD_0000);
        @(negedge clk);
        chk("w0_complete_wen", complete_wen, 1'b0);
        chk("w0_complete_val", complete_val, 1'b1);
        step();
        ex_val = '0;
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_cval", c), commit_val, 2'b01);
            chk($sformatf("hold%0d_cwen", c), commit_wen[0], 1'b0);
            chk($sformatf("hold%0d_seq", c), commit_seq_num[4:0], 5'd0);
            chk($sformatf("hold%0d_wdata", c), commit_wdata[31:0], 32'hDEAD_0000);
            step();
        end
        commit_rdy = 1'b1;
        @(negedge clk);
`ifdef WRITEBACK_COMMIT_UNIT_L4_PERF_EN
        chk("hold_perf_stall", perf_stall_cnt, 32'd3);
`endif
        chk("hold_release_cval", commit_val, 2'b01);
        step();
        @(negedge clk);
        chk("hold_done_cval", commit_val, 2'b00);

        // reset with two entries valid and one in the capture stage
        do_reset();
        drive(0, 5'd0, 5'd1, 32'h0);
        step();
        drive(0, 5'd1, 5'd1, 32'h1);
        step();
        drive(0, 5'd2, 5'd1, 32'h2);
        step();
        ex_val = '0;
        @(negedge clk);
        chk("mrst_pre_cval", commit_val, 2'b11);
        rst = 1'b0;
        drive(0, 5'd3, 5'd1, 32'h3);
        drive(1, 5'd4, 5'd1, 32'h4);
        #1;
        chk("mrst_in_rdy", ex_rdy, 2'b00);
        chk("mrst_in_cmpval", complete_val, 1'b0);
        chk("mrst_in_cval", commit_val, 2'b00);
        step();
        ex_val = '0;
        step();
        rst        = 1'b1;
        commit_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mrst_post%0d_cval", c), commit_val, 2'b00);
            chk($sformatf("mrst_post%0d_head", c), commit_seq_num[4:0], 5'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
